// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocate, out-of-order ALU/LSB writeback, up to two in-order commits per cycle.
// Optional ROB_BYPASS_EN: operand lookups also see same-cycle writebacks.
module rob_multi #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int LSB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              rob_full,
  output logic [IDX_W:0]    rob_count,
  output logic [IDX_W-1:0]  alloc_pos,
  input  logic              push,
  input  logic [1:0]        push_kind,
  input  logic [REG_W-1:0]  push_rd,
  input  logic [DATA_W-1:0] push_pc,
  input  logic [LSB_W-1:0]  push_lsbpos,
  input  logic              alu_flag,
  input  logic [IDX_W-1:0]  alu_robpos,
  input  logic [DATA_W-1:0] alu_val,
  input  logic              alu_isjump,
  input  logic [DATA_W-1:0] alu_jumpto,
  input  logic              lsb_in_flag,
  input  logic [IDX_W-1:0]  lsb_robpos,
  input  logic [DATA_W-1:0] lsb_val,
  input  logic              rs1_flag,
  input  logic [IDX_W-1:0]  rs1_robpos,
  output logic              rs1_ok,
  output logic [DATA_W-1:0] rs1_val,
  input  logic              rs2_flag,
  input  logic [IDX_W-1:0]  rs2_robpos,
  output logic              rs2_ok,
  output logic [DATA_W-1:0] rs2_val,
  output logic              unlock0,
  output logic [REG_W-1:0]  unlock_rd0,
  output logic [IDX_W-1:0]  unlock_robpos0,
  output logic [DATA_W-1:0] unlock_val0,
  output logic              unlock1,
  output logic [REG_W-1:0]  unlock_rd1,
  output logic [IDX_W-1:0]  unlock_robpos1,
  output logic [DATA_W-1:0] unlock_val1,
  output logic              rob_store_flag,
  output logic [LSB_W-1:0]  rob_store_lsbpos,
  output logic              jump,
  output logic [DATA_W-1:0] pc_jumpto,
  output logic              rob_clear
);

  typedef enum logic [1:0] {
    K_REG    = 2'd0,
    K_STORE  = 2'd1,
    K_BRANCH = 2'd2,
    K_JUMP   = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e             kind;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] pc;
    logic [LSB_W-1:0]  lsbpos;
    logic [DATA_W-1:0] val;
    logic              isjump;
    logic [DATA_W-1:0] jumpto;
  } entry_t;

  entry_t            ent_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, done_q;
  logic [IDX_W-1:0]  head_q, tail_q, head1;
  logic [IDX_W:0]    count_q;

  entry_t e0, e1;
  logic   s0, s1, redirect, flush, push_ok;
  logic   fire0, fire1, st0, st1;

  assign rob_full  = (count_q == (IDX_W+1)'(DEPTH));
  assign rob_count = count_q;
  assign alloc_pos = tail_q;

  assign head1 = head_q + IDX_W'(1);
  assign e0    = ent_q[head_q];
  assign e1    = ent_q[head1];

  // Slot 1 may not retire behind a taken redirect, nor as a second store (one release port).
  assign s0       = (count_q != '0) && done_q[head_q];
  assign redirect = s0 && (e0.kind == K_BRANCH || e0.kind == K_JUMP) && e0.isjump;
  assign s1       = s0 && (count_q >= (IDX_W+1)'(2)) && done_q[head1] && !redirect
                    && !(e0.kind == K_STORE && e1.kind == K_STORE);
  assign flush    = clear || redirect;
  assign push_ok  = push && !rob_full && !flush;

  assign fire0 = s0 && (e0.kind == K_REG || e0.kind == K_JUMP);
  assign fire1 = s1 && (e1.kind == K_REG || e1.kind == K_JUMP);
  assign st0   = s0 && (e0.kind == K_STORE);
  assign st1   = s1 && (e1.kind == K_STORE);

  function automatic logic [DATA_W:0] lookup(input logic flag, input logic [IDX_W-1:0] pos);
    logic              ok;
    logic [DATA_W-1:0] v;
    ok = flag && valid_q[pos] && done_q[pos];
    v  = ent_q[pos].val;
`ifdef ROB_BYPASS_EN
    if (flag && valid_q[pos] && lsb_in_flag && lsb_robpos == pos) begin
      ok = 1'b1;
      v  = lsb_val;
    end
    if (flag && valid_q[pos] && alu_flag && alu_robpos == pos) begin
      ok = 1'b1;
      v  = alu_val;
    end
`endif
    if (!ok) v = '0;
    return {ok, v};
  endfunction

  assign {rs1_ok, rs1_val} = lookup(rs1_flag, rs1_robpos);
  assign {rs2_ok, rs2_val} = lookup(rs2_flag, rs2_robpos);

  // Pointer, occupancy and per-entry status bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      // NOTE: later non-blocking writes to the same bit win, so commit clears override writeback sets.
      if (alu_flag && valid_q[alu_robpos])    done_q[alu_robpos] <= 1'b1;
      if (lsb_in_flag && valid_q[lsb_robpos]) done_q[lsb_robpos] <= 1'b1;
      if (s0) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (s1) begin
        valid_q[head1] <= 1'b0;
        done_q[head1]  <= 1'b0;
      end
      if (push_ok) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= (push_kind == K_STORE);
        tail_q          <= tail_q + IDX_W'(1);
      end
      head_q  <= head_q + IDX_W'(s0) + IDX_W'(s1);
      count_q <= count_q - (IDX_W+1)'(s0) - (IDX_W+1)'(s1) + (IDX_W+1)'(push_ok);
    end
  end

  // NOTE: the payload array is deliberately not reset; valid_q gates every observable read.
  always_ff @(posedge clk) begin
    if (push_ok)
      ent_q[tail_q] <= '{kind: kind_e'(push_kind), rd: push_rd, pc: push_pc,
                         lsbpos: push_lsbpos, val: '0, isjump: 1'b0, jumpto: '0};
    if (lsb_in_flag && valid_q[lsb_robpos])
      ent_q[lsb_robpos].val <= lsb_val;
    if (alu_flag && valid_q[alu_robpos]) begin
      ent_q[alu_robpos].val    <= alu_val;
      ent_q[alu_robpos].isjump <= alu_isjump;
      ent_q[alu_robpos].jumpto <= alu_jumpto;
    end
  end

  // Commit-side pulses; an external clear suppresses everything retiring on that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unlock0          <= 1'b0;
      unlock_rd0       <= '0;
      unlock_robpos0   <= '0;
      unlock_val0      <= '0;
      unlock1          <= 1'b0;
      unlock_rd1       <= '0;
      unlock_robpos1   <= '0;
      unlock_val1      <= '0;
      rob_store_flag   <= 1'b0;
      rob_store_lsbpos <= '0;
      jump             <= 1'b0;
      pc_jumpto        <= '0;
      rob_clear        <= 1'b0;
    end else begin
      unlock0          <= !clear && fire0;
      unlock_rd0       <= (!clear && fire0) ? e0.rd  : '0;
      unlock_robpos0   <= (!clear && fire0) ? head_q : '0;
      unlock_val0      <= (!clear && fire0) ? e0.val : '0;
      unlock1          <= !clear && fire1;
      unlock_rd1       <= (!clear && fire1) ? e1.rd  : '0;
      unlock_robpos1   <= (!clear && fire1) ? head1  : '0;
      unlock_val1      <= (!clear && fire1) ? e1.val : '0;
      rob_store_flag   <= !clear && (st0 || st1);
      rob_store_lsbpos <= clear ? '0 : st0 ? e0.lsbpos : st1 ? e1.lsbpos : '0;
      jump             <= !clear && redirect;
      pc_jumpto        <= (!clear && redirect) ? e0.jumpto : '0;
      rob_clear        <= !clear && redirect;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: reset, dual commit, redirect, full/wrap, store serialisation, lookup.
module tb_rob_multi;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int LSB_W  = 4;
`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk, reset, clear;
  logic              rob_full;
  logic [IDX_W:0]    rob_count;
  logic [IDX_W-1:0]  alloc_pos;
  logic              push;
  logic [1:0]        push_kind;
  logic [REG_W-1:0]  push_rd;
  logic [DATA_W-1:0] push_pc;
  logic [LSB_W-1:0]  push_lsbpos;
  logic              alu_flag, alu_isjump;
  logic [IDX_W-1:0]  alu_robpos;
  logic [DATA_W-1:0] alu_val, alu_jumpto;
  logic              lsb_in_flag;
  logic [IDX_W-1:0]  lsb_robpos;
  logic [DATA_W-1:0] lsb_val;
  logic              rs1_flag, rs2_flag, rs1_ok, rs2_ok;
  logic [IDX_W-1:0]  rs1_robpos, rs2_robpos;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic              unlock0, unlock1;
  logic [REG_W-1:0]  unlock_rd0, unlock_rd1;
  logic [IDX_W-1:0]  unlock_robpos0, unlock_robpos1;
  logic [DATA_W-1:0] unlock_val0, unlock_val1;
  logic              rob_store_flag, jump, rob_clear;
  logic [LSB_W-1:0]  rob_store_lsbpos;
  logic [DATA_W-1:0] pc_jumpto;

  int n_checks = 0;
  int n_pass   = 0;

  rob_multi #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W), .LSB_W(LSB_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .rob_full(rob_full), .rob_count(rob_count), .alloc_pos(alloc_pos),
    .push(push), .push_kind(push_kind), .push_rd(push_rd), .push_pc(push_pc),
    .push_lsbpos(push_lsbpos),
    .alu_flag(alu_flag), .alu_robpos(alu_robpos), .alu_val(alu_val),
    .alu_isjump(alu_isjump), .alu_jumpto(alu_jumpto),
    .lsb_in_flag(lsb_in_flag), .lsb_robpos(lsb_robpos), .lsb_val(lsb_val),
    .rs1_flag(rs1_flag), .rs1_robpos(rs1_robpos), .rs1_ok(rs1_ok), .rs1_val(rs1_val),
    .rs2_flag(rs2_flag), .rs2_robpos(rs2_robpos), .rs2_ok(rs2_ok), .rs2_val(rs2_val),
    .unlock0(unlock0), .unlock_rd0(unlock_rd0), .unlock_robpos0(unlock_robpos0),
    .unlock_val0(unlock_val0),
    .unlock1(unlock1), .unlock_rd1(unlock_rd1), .unlock_robpos1(unlock_robpos1),
    .unlock_val1(unlock_val1),
    .rob_store_flag(rob_store_flag), .rob_store_lsbpos(rob_store_lsbpos),
    .jump(jump), .pc_jumpto(pc_jumpto), .rob_clear(rob_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [1:0] kind, input logic [REG_W-1:0] rd,
                            input logic [LSB_W-1:0] lsbpos);
    push        = 1'b1;
    push_kind   = kind;
    push_rd     = rd;
    push_pc     = 32'h1000 + 32'(rd);
    push_lsbpos = lsbpos;
    tick();
    push = 1'b0;
  endtask

  task automatic alu_write(input logic [IDX_W-1:0] pos, input logic [DATA_W-1:0] val,
                           input logic isj, input logic [DATA_W-1:0] jt);
    alu_flag   = 1'b1;
    alu_robpos = pos;
    alu_val    = val;
    alu_isjump = isj;
    alu_jumpto = jt;
    tick();
    alu_flag = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; push = 1'b0; push_kind = '0; push_rd = '0; push_pc = '0;
    push_lsbpos = '0; alu_flag = 1'b0; alu_robpos = '0; alu_val = '0; alu_isjump = 1'b0;
    alu_jumpto = '0; lsb_in_flag = 1'b0; lsb_robpos = '0; lsb_val = '0;
    rs1_flag = 1'b0; rs1_robpos = '0; rs2_flag = 1'b0; rs2_robpos = '0;

    // Reset, then reset again mid-run with five entries queued.
    #12;
    check("por_count", rob_count, 0);
    check("por_unlock0", unlock0, 0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push_entry(2'd0, 5'(i + 1), '0);
    check("pre_rst_count", rob_count, 5);
    check("pre_rst_alloc", alloc_pos, 5);
    #2 reset = 1'b0;
    #1;
    check("rst_count", rob_count, 0);
    check("rst_full", rob_full, 0);
    check("rst_jump", jump, 0);
    check("rst_store", rob_store_flag, 0);
    reset = 1'b1;
    tick();
    check("rel_count", rob_count, 0);
    check("rel_alloc", alloc_pos, 0);

    // Out-of-order completion, dual commit in one cycle.
    push_entry(2'd0, 5'd3, '0);
    push_entry(2'd0, 5'd4, '0);
    alu_write(4'd1, 32'h22, 1'b0, '0);
    check("ooo_no_commit", unlock0, 0);
    check("ooo_count", rob_count, 2);
    alu_write(4'd0, 32'h11, 1'b0, '0);
    tick();
    check("dual_u0", unlock0, 1);
    check("dual_rd0", unlock_rd0, 3);
    check("dual_val0", unlock_val0, 32'h11);
    check("dual_pos0", unlock_robpos0, 0);
    check("dual_u1", unlock1, 1);
    check("dual_rd1", unlock_rd1, 4);
    check("dual_val1", unlock_val1, 32'h22);
    check("dual_pos1", unlock_robpos1, 1);
    check("dual_count", rob_count, 0);
    tick();
    check("dual_pulse_end", unlock0, 0);

    // Taken branch at slot 0 redirects and flushes; a same-cycle push is discarded.
    check("br_alloc", alloc_pos, 2);
    push_entry(2'd2, 5'd0, '0);
    push_entry(2'd0, 5'd7, '0);
    alu_write(4'd3, 32'h33, 1'b0, '0);
    alu_write(4'd2, 32'h0, 1'b1, 32'h100);
    push = 1'b1; push_kind = 2'd0; push_rd = 5'd9;
    tick();
    push = 1'b0;
    check("br_jump", jump, 1);
    check("br_clear", rob_clear, 1);
    check("br_target", pc_jumpto, 32'h100);
    check("br_no_u0", unlock0, 0);
    check("br_no_u1", unlock1, 0);
    check("br_count", rob_count, 0);
    check("br_alloc0", alloc_pos, 0);
    tick();
    check("br_pulse_end", jump, 0);

    // Fill to full, reject overflow, commit while full, wrap the tail.
    for (int i = 0; i < DEPTH; i++) push_entry(2'd0, 5'(i), '0);
    check("full_flag", rob_full, 1);
    check("full_count", rob_count, 16);
    push_entry(2'd0, 5'd31, '0);
    check("ovf_count", rob_count, 16);
    check("ovf_alloc", alloc_pos, 0);
    alu_write(4'd1, 32'h101, 1'b0, '0);
    alu_write(4'd0, 32'h100, 1'b0, '0);
    push = 1'b1; push_kind = 2'd0; push_rd = 5'd30;
    tick();
    push = 1'b0;
    check("fc_u0_pos", unlock_robpos0, 0);
    check("fc_u0_val", unlock_val0, 32'h100);
    check("fc_u1_rd", unlock_rd1, 1);
    check("fc_u1_pos", unlock_robpos1, 1);
    check("fc_count", rob_count, 14);
    push_entry(2'd0, 5'd20, '0);
    push_entry(2'd0, 5'd21, '0);
    check("wrap_count", rob_count, 16);
    check("wrap_alloc", alloc_pos, 2);
    alu_write(4'd3, 32'h103, 1'b0, '0);
    check("order_hold", unlock0, 0);
    alu_write(4'd2, 32'h102, 1'b0, '0);
    tick();
    check("order_pos0", unlock_robpos0, 2);
    check("order_val0", unlock_val0, 32'h102);
    check("order_pos1", unlock_robpos1, 3);
    check("order_count", rob_count, 14);

    // External clear overrides a commit that was due on the same edge.
    alu_write(4'd4, 32'h104, 1'b0, '0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_u0", unlock0, 0);
    check("clr_count", rob_count, 0);
    check("clr_alloc", alloc_pos, 0);

    // ALU beats LSB on the same index; two adjacent stores retire one per cycle.
    push_entry(2'd0, 5'd10, '0);
    push_entry(2'd0, 5'd11, '0);
    push_entry(2'd1, 5'd0, 4'd3);
    push_entry(2'd1, 5'd0, 4'd7);
    lsb_in_flag = 1'b1; lsb_robpos = 4'd1; lsb_val = 32'h44;
    tick();
    lsb_robpos = 4'd0; lsb_val = 32'h99;
    alu_write(4'd0, 32'h40, 1'b0, '0);
    lsb_in_flag = 1'b0;
    tick();
    check("prio_val0", unlock_val0, 32'h40);
    check("lsb_val1", unlock_val1, 32'h44);
    check("st_none", rob_store_flag, 0);
    check("st_count2", rob_count, 2);
    tick();
    check("st_a_flag", rob_store_flag, 1);
    check("st_a_pos", rob_store_lsbpos, 3);
    check("st_a_no_u0", unlock0, 0);
    check("st_a_count", rob_count, 1);
    tick();
    check("st_b_flag", rob_store_flag, 1);
    check("st_b_pos", rob_store_lsbpos, 7);
    check("st_b_count", rob_count, 0);
    tick();
    check("st_end", rob_store_flag, 0);

    // Operand lookup with and without same-cycle writeback visibility.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push_entry(2'd0, 5'd1, '0);
    push_entry(2'd0, 5'd2, '0);
    push_entry(2'd0, 5'd3, '0);
    rs1_flag = 1'b1; rs1_robpos = 4'd2;
    rs2_flag = 1'b1; rs2_robpos = 4'd0;
    alu_flag = 1'b1; alu_robpos = 4'd2; alu_val = 32'h55; alu_isjump = 1'b0;
    #1;
    check("lk_same_ok", rs1_ok, BYP);
    check("lk_same_val", rs1_val, BYP ? 32'h55 : 32'h0);
    check("lk_pend_ok", rs2_ok, 0);
    check("lk_pend_val", rs2_val, 0);
    tick();
    alu_flag = 1'b0;
    #1;
    check("lk_next_ok", rs1_ok, 1);
    check("lk_next_val", rs1_val, 32'h55);
    alu_write(4'd0, 32'h66, 1'b0, '0);
    check("lk_commit_ok", rs2_ok, 1);
    check("lk_commit_val", rs2_val, 32'h66);
    tick();
    check("lk_commit_u0", unlock_val0, 32'h66);
    check("lk_gone_ok", rs2_ok, 0);
    rs1_flag = 1'b0;
    #1;
    check("lk_noreq_ok", rs1_ok, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised reorder buffer; successor to the single-commit ROB.
- Sits between the issue stage and the regfile, LSB and fetch.
- Accepts one instruction per cycle in program order, receives out-of-order results from an ALU port and an LSB load port, and retires up to two entries per cycle in order.
- Drives regfile unlock, store release and branch redirect, and answers two operand lookups per cycle.

Parameters:
- DEPTH, 16, number of entries; power of 2, at least 4.
- IDX_W, 4, log2(DEPTH).
- DATA_W, 32, result/PC width.
- REG_W, 5, architectural register index width.
- LSB_W, 4, LSB slot index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous external flush.
- rob_full  out  1  combinational: count==DEPTH.
- rob_count  out  IDX_W+1  combinational occupancy.
- alloc_pos  out  IDX_W  combinational: tail index for the next push.
- push  in  1  allocate entry at tail.
- push_kind  in  2  0=reg-write, 1=store, 2=branch, 3=jump (writes rd, may redirect).
- push_rd  in  REG_W  destination register.
- push_pc  in  DATA_W  instruction PC.
- push_lsbpos  in  LSB_W  LSB slot, used by stores.
- alu_flag  in  1  ALU writeback valid.
- alu_robpos  in  IDX_W  ALU target entry.
- alu_val  in  DATA_W  ALU result.
- alu_isjump  in  1  redirect required.
- alu_jumpto  in  DATA_W  redirect target.
- lsb_in_flag  in  1  load writeback valid.
- lsb_robpos  in  IDX_W  load target entry.
- lsb_val  in  DATA_W  load result.
- rs1_flag, rs2_flag  in  1  lookup request.
- rs1_robpos, rs2_robpos  in  IDX_W  lookup index.
- rs1_ok, rs2_ok  out  1  combinational: entry valid and done.
- rs1_val, rs2_val  out  DATA_W  combinational value; 0 when not ok.
- unlock0, unlock1  out  1  registered commit pulses, slot 0/1.
- unlock_rd0, unlock_rd1  out  REG_W  committed rd.
- unlock_robpos0, unlock_robpos1  out  IDX_W  committed index.
- unlock_val0, unlock_val1  out  DATA_W  committed value.
- rob_store_flag  out  1  registered store-release pulse.
- rob_store_lsbpos  out  LSB_W  LSB slot to release.
- jump  out  1  registered redirect pulse.
- pc_jumpto  out  DATA_W  redirect target.
- rob_clear  out  1  registered flush pulse to the rest of the core, coincident with jump.

Behaviour:
- Reset (reset low, async):
  - head=tail=count=0; all valid/done bits 0.
  - All registered outputs 0.
- Entry state: valid, done, kind, rd, pc, lsbpos, val, isjump, jumpto.
- Push:
  - Accepted when push && !rob_full; writes at tail; tail wraps DEPTH-1->0.
  - Store entries have done=1 at allocation.
  - push while full: ignored, no state change.
- Writeback:
  - ALU writes val/isjump/jumpto and sets done.
  - LSB writes val and sets done.
  - Writebacks to entries with valid=0 are dropped.
  - ALU and LSB hitting the same index in one cycle: ALU wins.
- Commit, evaluated on pre-edge state:
  - s0 = (count>=1 && done[head]).
  - s1 = s0 && count>=2 && done[head+1] && !(kind[head] in {branch,jump} && isjump[head]) && !(both store).
  - head advances by s0+s1 mod DEPTH.
  - count_next = count - s0 - s1 + accepted_push.
- Per committed slot:
  - reg-write or jump: unlockN=1 with rd/robpos/val.
  - store: rob_store_flag=1 with lsbpos.
  - branch: no unlock.
  - Outputs are one-cycle pulses, deasserted otherwise.
- Redirect:
  - Slot 0 committing branch/jump with isjump=1 sets jump=1, rob_clear=1, pc_jumpto=jumpto.
  - The same edge empties the ROB (head=tail=count=0, valid cleared).
  - A push in that cycle is discarded.
- Clear:
  - Same-edge empty as redirect.
  - Commit outputs forced 0; has priority over push, writeback and commit.
- Full and commit in the same cycle: the push is still rejected. No same-cycle reuse of a freed slot.
- Lookup: reads pre-edge state; an entry committing this cycle is still visible.

Optional Feature:
- Macro ROB_BYPASS_EN.
- Defined:
  - rsN_ok also asserts when a same-cycle alu_flag/lsb_in_flag targets rsN_robpos.
  - rsN_val takes the incoming value, ALU over LSB.
- Undefined: lookup sees stored done/val only; a value written this cycle is visible next cycle.

Test Plan:
- Reset low mid-run with count=5 -> all outputs 0 immediately; after release rob_count=0, alloc_pos=0.
- Push reg-writes at idx 0 and 1; ALU writes idx1=0x22 then idx0=0x11 -> single cycle with unlock0 (rd, 0x11) and unlock1 (0x22); rob_count 2->0.
- Push branch idx0 and reg-write idx1, both done, branch isjump=1, jumpto=0x100 -> jump=1, pc_jumpto=0x100, rob_clear=1; idx1 not unlocked; rob_count=0 next cycle.
- Push DEPTH=16 entries -> rob_full=1; a 17th push is ignored. Commit 2, push 2 -> tail wraps to 0/1; entries retire in order.
- Two adjacent done stores, lsbpos 3 and 7 -> rob_store_flag with 3, then next cycle with 7; never two stores in one cycle.
- rs1 lookup of idx2 while ALU writes idx2=0x55 -> with ROB_BYPASS_EN rs1_ok=1, rs1_val=0x55 same cycle; without it rs1_ok=0, then 1 the next cycle.
